// File: rtl/diwall_pkg.sv
// Shared detector/sampler definitions.
// Alert classes match the detector's own encodings.
package diwall_pkg;

  typedef enum logic [1:0] {
    ALERT_LEGIT = 2'b00,
    ALERT_STACK = 2'b10,
    ALERT_HEAP  = 2'b11
  } alert_e;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_WAIT = 2'd2
  } hs_state_e;

  localparam int unsigned FEAT_IMISS = 0;
  localparam int unsigned FEAT_JMP   = 1;
  localparam int unsigned OVR_W      = 16;

endpackage

// File: rtl/hpm_sat_counter.sv
// Saturating event counter with synchronous clear.
// nxt_o exposes this cycle's value including its own event.
module hpm_sat_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/hpm_window_sampler.sv
// Windowed HPM feature sampler with detector handshake.
// Snapshots live counters at each window end and requests analysis.
module hpm_window_sampler
  import diwall_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned CNT_W         = 64
) (
  input  logic                  clk_h,
  input  logic                  rst_h,
  input  logic                  run_i,
  input  logic                  imiss_i,
  input  logic                  jmp_stall_i,
  output logic [1:0][CNT_W-1:0] hpm_o,
  output logic                  enable_d_o,
  input  logic                  end_d_i,
  input  logic [1:0]            alert_i,
  output logic [1:0]            alert_o,
  output logic                  alert_valid_o,
  output logic [15:0]           overrun_cnt_o
);

  localparam logic [31:0] WIN_LAST = 32'(WINDOW_CYCLES - 1);

  hs_state_e              hs_q, hs_d;
  logic [31:0]            win_q, win_d;
  logic [1:0][CNT_W-1:0]  hpm_q, hpm_d;
  alert_e                 alert_q, alert_d;
  logic                   avld_q, avld_d;

  logic term, live_clr, load, ovr;
  logic [CNT_W-1:0] im_nxt, js_nxt;
  logic [CNT_W-1:0] im_cnt_unused, js_cnt_unused;
  logic [OVR_W-1:0] ovr_nxt_unused;

  assign term     = run_i && (win_q == WIN_LAST);
  assign live_clr = !run_i || term;
  assign load     = term && (hs_q == HS_IDLE);
  assign ovr      = term && (hs_q != HS_IDLE);

  hpm_sat_counter #(.W(CNT_W)) u_imiss (
    .clk_i (clk_h),
    .rst_i (rst_h),
    .clr_i (live_clr),
    .inc_i (imiss_i),
    .cnt_o (im_cnt_unused),
    .nxt_o (im_nxt)
  );

  hpm_sat_counter #(.W(CNT_W)) u_jmp (
    .clk_i (clk_h),
    .rst_i (rst_h),
    .clr_i (live_clr),
    .inc_i (jmp_stall_i),
    .cnt_o (js_cnt_unused),
    .nxt_o (js_nxt)
  );

  hpm_sat_counter #(.W(OVR_W)) u_ovr (
    .clk_i (clk_h),
    .rst_i (rst_h),
    .clr_i (1'b0),
    .inc_i (ovr),
    .cnt_o (overrun_cnt_o),
    .nxt_o (ovr_nxt_unused)
  );

  always_comb begin
    hs_d    = hs_q;
    hpm_d   = hpm_q;
    alert_d = alert_q;
    avld_d  = 1'b0;
    win_d   = live_clr ? '0 : win_q + 32'd1;
    unique case (hs_q)
      HS_IDLE: if (load) hs_d = HS_REQ;
      HS_REQ:  hs_d = HS_WAIT;
      HS_WAIT: begin
        if (end_d_i) begin
          hs_d    = HS_IDLE;
          alert_d = alert_e'(alert_i);
          avld_d  = 1'b1;
        end
      end
      default: hs_d = HS_IDLE;
    endcase
    // terminal-cycle events are already folded into *_nxt
    if (load) begin
      hpm_d[FEAT_IMISS] = im_nxt;
      hpm_d[FEAT_JMP]   = js_nxt;
    end
  end

  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      hs_q    <= HS_IDLE;
      win_q   <= '0;
      hpm_q   <= '0;
      alert_q <= ALERT_LEGIT;
      avld_q  <= 1'b0;
    end else begin
      hs_q    <= hs_d;
      win_q   <= win_d;
      hpm_q   <= hpm_d;
      alert_q <= alert_d;
      avld_q  <= avld_d;
    end
  end

  assign hpm_o         = hpm_q;
  assign enable_d_o    = (hs_q == HS_REQ);
  assign alert_o       = alert_q;
  assign alert_valid_o = avld_q;

endmodule

// File: doc/hpm_window_sampler.md
HPM_WINDOW_SAMPLER -- requirements
Module: hpm_window_sampler

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 1024, meaning the sampling window length in clk_h cycles; legal range 2..2^32-1.
REQ-002 SHALL have parameter CNT_W, default 64, meaning the width of each feature counter.
REQ-003 SHALL have port clk_h, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_h, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port run_i, input, 1 bit: monitoring enable (level).
REQ-006 SHALL have port imiss_i, input, 1 bit: instruction-miss event strobe, one event per high cycle.
REQ-007 SHALL have port jmp_stall_i, input, 1 bit: jump-stall event strobe, one event per high cycle.
REQ-008 SHALL have port hpm_o, output, [1:0][CNT_W-1:0]: frozen feature snapshot; [0]=IMISS count, [1]=JMP_STALL count.
REQ-009 SHALL have port enable_d_o, output, 1 bit: one-cycle analyze request to the detector.
REQ-010 SHALL have port end_d_i, input, 1 bit: detector done strobe.
REQ-011 SHALL have port alert_i, input, 2 bits: detector class (00 legit, 10 stack, 11 heap), valid while end_d_i=1.
REQ-012 SHALL have port alert_o, output, 2 bits: latched class of the last completed analysis.
REQ-013 SHALL have port alert_valid_o, output, 1 bit: one-cycle pulse when alert_o updates.
REQ-014 SHALL have port overrun_cnt_o, output, 16 bits: count of windows dropped because the detector was busy.

Function
REQ-015 SHALL, while run_i=1, increment the window counter every cycle and each live counter on every cycle its strobe is high, saturating at 2^CNT_W-1.
REQ-016 SHALL treat the cycle where the window counter equals WINDOW_CYCLES-1 as the terminal cycle; events in that cycle belong to the ending window.
REQ-017 SHALL, on the terminal cycle, clear the window counter and both live counters so events in the next cycle start the new window at 1.
REQ-018 SHALL, on the terminal cycle with the handshake in HS_IDLE, load hpm_o with the final live values, and assert enable_d_o on the following cycle only.
REQ-019 SHALL run the handshake FSM HS_IDLE -> HS_REQ (enable_d_o=1, exactly one cycle) -> HS_WAIT (until end_d_i=1) -> HS_IDLE.
REQ-020 SHALL, on end_d_i=1 in HS_WAIT, latch alert_i into alert_o and pulse alert_valid_o on the next cycle.
REQ-021 SHALL ignore end_d_i outside HS_WAIT.
REQ-022 SHALL hold hpm_o constant from load until the next load.
REQ-023 SHALL, on a terminal cycle with the handshake not in HS_IDLE, leave hpm_o unchanged, still clear live counters, and increment overrun_cnt_o, saturating at 0xFFFF.
REQ-024 SHALL, when run_i falls mid-window, discard the partial window: clear the window and live counters next cycle, with no snapshot or overrun.
REQ-025 SHALL let an in-flight handshake complete regardless of run_i.
REQ-026 SHALL restart counting from zero on the first cycle run_i=1 after it was low.
REQ-027 SHALL count no events while run_i=0.

Reset
REQ-028 SHALL, with rst_h=1 at a clk_h edge, set hpm_o=0, enable_d_o=0, alert_o=00, alert_valid_o=0, overrun_cnt_o=0, clear all counters, and enter HS_IDLE.
REQ-029 SHALL abandon any in-flight window or handshake on reset, with no alert_valid_o pulse.

Structure
REQ-030 SHALL take the alert class encodings and handshake state enum from the shared package diwall_pkg, alongside the detector's class encodings.
REQ-031 SHALL implement the saturating counter as one sub-module, hpm_sat_counter, instantiated for IMISS, JMP_STALL and overrun.

Verification
REQ-032 SHALL check: WINDOW_CYCLES=16, run_i=1, imiss_i high 5 cycles, jmp_stall_i high 3 cycles -> hpm_o={3,5} after the terminal cycle, enable_d_o high exactly 1 cycle.
REQ-033 SHALL check: imiss_i high on the terminal cycle and the following cycle -> snapshot includes the first event, and the next window starts at 1.
REQ-034 SHALL check: end_d_i held low for 40 cycles with WINDOW_CYCLES=16 -> overrun_cnt_o=2 and hpm_o unchanged.
REQ-035 SHALL check: end_d_i=1 with alert_i=11 in HS_WAIT -> alert_o=11 and a one-cycle alert_valid_o pulse; end_d_i in HS_IDLE -> no pulse.
REQ-036 SHALL check: run_i dropped at window cycle 7 -> no enable_d_o pulse, and run_i re-raised -> a full 16 cycles to the next pulse.
REQ-037 SHALL check: rst_h asserted during HS_WAIT -> all outputs 0 on the next cycle, and a later end_d_i produces no alert.
